rr_ex_operand_latch: RTL and testbench

Register-read to execute pipeline latch for one issue lane, sitting directly downstream of the per-operand bypass muxes. It captures the lane's post-bypass source operands plus destination tag and control payload. It presents them to the functional unit with a valid/ready handshake. While an entry is held by a downstream stall, it keeps snooping the bypass network so held operands never go stale. It also counts stall cycles for performance monitoring.

---
 rtl/rr_ex_operand_latch.sv | 123 ++++++++++++
 tb/tb_rr_ex_operand_latch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_ex_operand_latch.sv
// Register-read to execute operand latch for one issue lane.
// Holds one instruction under a valid/ready handshake and keeps its operands fresh from the bypass network while stalled.
//
// state | meaning
// EMPTY | no entry held, valid_o=0
// FULL  | entry held and presented to execute, valid_o=1
module rr_ex_operand_latch #(
    parameter int ISSUE_WIDTH       = 4,
    parameter int SIZE_DATA         = 64,
    parameter int SIZE_PHYSICAL_LOG = 7,
    parameter int CTRL_W            = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [SIZE_PHYSICAL_LOG-1:0]           phySrc1_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]           phySrc2_i,
    input  logic [SIZE_DATA-1:0]                   src1Data_i,
    input  logic [SIZE_DATA-1:0]                   src2Data_i,
    input  logic [SIZE_PHYSICAL_LOG-1:0]           phyDest_i,
    input  logic [CTRL_W-1:0]                      ctrl_i,
    input  logic [ISSUE_WIDTH-1:0]                 bypassValid_i,
    input  logic [ISSUE_WIDTH*SIZE_PHYSICAL_LOG-1:0] bypassTag_i,
    input  logic [ISSUE_WIDTH*SIZE_DATA-1:0]       bypassData_i,
    input  logic                                   flush_i,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic [SIZE_DATA-1:0]                   src1Data_o,
    output logic [SIZE_DATA-1:0]                   src2Data_o,
    output logic [SIZE_PHYSICAL_LOG-1:0]           phyDest_o,
    output logic [CTRL_W-1:0]                      ctrl_o,
    output logic [3:0]                             stallCnt_o
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t                         state_q, state_d;
    logic [SIZE_DATA-1:0]           src1_q, src1_d, src2_q, src2_d;
    logic [SIZE_DATA-1:0]           snoop1, snoop2;
    logic [SIZE_PHYSICAL_LOG-1:0]   tag1_q, tag1_d, tag2_q, tag2_d;
    logic [SIZE_PHYSICAL_LOG-1:0]   dest_q, dest_d;
    logic [CTRL_W-1:0]              ctrl_q, ctrl_d;
    logic [3:0]                     stall_q, stall_d;
    logic                           load;

    assign valid_o    = (state_q == FULL);
    assign ready_o    = !valid_o || ready_i;
    assign load       = valid_i && ready_o && !flush_i;
    assign src1Data_o = src1_q;
    assign src2Data_o = src2_q;
    assign phyDest_o  = dest_q;
    assign ctrl_o     = ctrl_q;
    assign stallCnt_o = stall_q;

    // Ascending scan so the highest matching lane is the last assignment and wins.
    always_comb begin
        snoop1 = src1_q;
        snoop2 = src2_q;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            if (bypassValid_i[k] && (bypassTag_i[k*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG] == tag1_q))
                snoop1 = bypassData_i[k*SIZE_DATA +: SIZE_DATA];
            if (bypassValid_i[k] && (bypassTag_i[k*SIZE_PHYSICAL_LOG +: SIZE_PHYSICAL_LOG] == tag2_q))
                snoop2 = bypassData_i[k*SIZE_DATA +: SIZE_DATA];
        end
    end

    always_comb begin
        state_d = state_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        tag1_d  = tag1_q;
        tag2_d  = tag2_q;
        dest_d  = dest_q;
        ctrl_d  = ctrl_q;
        stall_d = stall_q;
        if (flush_i) begin
            state_d = EMPTY;
            stall_d = 4'd0;
        end else if (load) begin
            state_d = FULL;
            src1_d  = src1Data_i;
            src2_d  = src2Data_i;
            tag1_d  = phySrc1_i;
            tag2_d  = phySrc2_i;
            dest_d  = phyDest_i;
            ctrl_d  = ctrl_i;
            stall_d = 4'd0;
        end else if (state_q == FULL) begin
            if (ready_i) begin
                state_d = EMPTY;
                stall_d = 4'd0;
            end else begin
                src1_d  = snoop1;
                src2_d  = snoop2;
                stall_d = (stall_q == 4'hF) ? stall_q : stall_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            src1_q  <= '0;
            src2_q  <= '0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            dest_q  <= '0;
            ctrl_q  <= '0;
            stall_q <= 4'd0;
        end else begin
            state_q <= state_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag2_d;
            dest_q  <= dest_d;
            ctrl_q  <= ctrl_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_rr_ex_operand_latch.sv
// Bench for rr_ex_operand_latch: vector table, hand-written corner sequences,
// then randomized traffic against an entry-level reference model.
module tb_rr_ex_operand_latch;

    localparam int IW = 4;
    localparam int SD = 64;
    localparam int SP = 7;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              valid_i, ready_o, flush_i, valid_o, ready_i;
    logic [SP-1:0]     phySrc1_i, phySrc2_i, phyDest_i, phyDest_o;
    logic [SD-1:0]     src1Data_i, src2Data_i, src1Data_o, src2Data_o;
    logic [CW-1:0]     ctrl_i, ctrl_o;
    logic [IW-1:0]     bypassValid_i;
    logic [IW*SP-1:0]  bypassTag_i;
    logic [IW*SD-1:0]  bypassData_i;
    logic [3:0]        stallCnt_o;

    int n_vec = 0;
    int n_err = 0;

    // Reference entry
    logic          m_valid;
    logic [SP-1:0] m_tag1, m_tag2, m_dest;
    logic [SD-1:0] m_src1, m_src2;
    logic [CW-1:0] m_ctrl;
    int            m_cnt;

    always #5 clk = ~clk;

    rr_ex_operand_latch #(.ISSUE_WIDTH(IW), .SIZE_DATA(SD), .SIZE_PHYSICAL_LOG(SP), .CTRL_W(CW)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
        .phySrc1_i(phySrc1_i), .phySrc2_i(phySrc2_i),
        .src1Data_i(src1Data_i), .src2Data_i(src2Data_i),
        .phyDest_i(phyDest_i), .ctrl_i(ctrl_i),
        .bypassValid_i(bypassValid_i), .bypassTag_i(bypassTag_i), .bypassData_i(bypassData_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .src1Data_o(src1Data_o), .src2Data_o(src2Data_o),
        .phyDest_o(phyDest_o), .ctrl_o(ctrl_o), .stallCnt_o(stallCnt_o)
    );

    typedef struct {
        logic          v, r, f;
        logic [SD-1:0] s1;
        logic [SP-1:0] dest;
        logic          e_rdy, e_v;
        logic [SD-1:0] e_s1;
        logic [SP-1:0] e_dest;
        logic [3:0]    e_cnt;
    } vec_t;

    vec_t tbl[11];

    function automatic vec_t mk(input logic v, r, f, input logic [SD-1:0] s1, input logic [SP-1:0] dest,
                                input logic e_rdy, e_v, input logic [SD-1:0] e_s1,
                                input logic [SP-1:0] e_dest, input logic [3:0] e_cnt);
        vec_t t;
        t.v = v; t.r = r; t.f = f; t.s1 = s1; t.dest = dest;
        t.e_rdy = e_rdy; t.e_v = e_v; t.e_s1 = e_s1; t.e_dest = e_dest; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [SD-1:0] act, input logic [SD-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Latest-numbered valid lane carrying the tag supplies the value.
    function automatic logic [SD-1:0] snoop(input logic [SP-1:0] tag, input logic [SD-1:0] cur);
        for (int k = IW - 1; k >= 0; k--)
            if (bypassValid_i[k] && bypassTag_i[k*SP +: SP] == tag)
                return bypassData_i[k*SD +: SD];
        return cur;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_tag1 = '0; m_tag2 = '0; m_dest = '0;
        m_src1 = '0; m_src2 = '0; m_ctrl = '0; m_cnt = 0;
    endtask

    task automatic model_step();
        logic accept;
        accept = valid_i && (!m_valid || ready_i);
        if (flush_i) begin
            m_valid = 1'b0;
            m_cnt   = 0;
        end else if (accept) begin
            m_valid = 1'b1;
            m_tag1 = phySrc1_i; m_tag2 = phySrc2_i;
            m_src1 = src1Data_i; m_src2 = src2Data_i;
            m_dest = phyDest_i; m_ctrl = ctrl_i;
            m_cnt  = 0;
        end else if (m_valid && ready_i) begin
            m_valid = 1'b0;
            m_cnt   = 0;
        end else if (m_valid) begin
            m_src1 = snoop(m_tag1, m_src1);
            m_src2 = snoop(m_tag2, m_src2);
            m_cnt  = (m_cnt < 15) ? m_cnt + 1 : 15;
        end
    endtask

    task automatic tick();
        #1;
        chk("ready_o", {63'd0, ready_o}, {63'd0, !m_valid || ready_i});
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model();
        chk("valid_o", {63'd0, valid_o}, {63'd0, m_valid});
        chk("stallCnt_o", {60'd0, stallCnt_o}, SD'(m_cnt));
        if (m_valid) begin
            chk("src1Data_o", src1Data_o, m_src1);
            chk("src2Data_o", src2Data_o, m_src2);
            chk("phyDest_o", {57'd0, phyDest_o}, {57'd0, m_dest});
            chk("ctrl_o", {32'd0, ctrl_o}, {32'd0, m_ctrl});
        end
    endtask

    task automatic clear_bypass();
        bypassValid_i = '0;
        bypassTag_i   = '0;
        bypassData_i  = '0;
    endtask

    task automatic set_lane(input int k, input logic [SP-1:0] tag, input logic [SD-1:0] data);
        bypassValid_i[k]       = 1'b1;
        bypassTag_i[k*SP +: SP] = tag;
        bypassData_i[k*SD +: SD] = data;
    endtask

    initial begin
        //           v     r     f     s1       dest  e_rdy e_v   e_s1     e_dest e_cnt
        tbl[0]  = mk(1'b1, 1'b1, 1'b0, 64'h10, 7'd1,  1'b1, 1'b1, 64'h10, 7'd1,  4'd0);
        tbl[1]  = mk(1'b1, 1'b1, 1'b0, 64'h11, 7'd2,  1'b1, 1'b1, 64'h11, 7'd2,  4'd0);
        tbl[2]  = mk(1'b1, 1'b1, 1'b0, 64'h12, 7'd3,  1'b1, 1'b1, 64'h12, 7'd3,  4'd0);
        tbl[3]  = mk(1'b1, 1'b1, 1'b0, 64'h13, 7'd4,  1'b1, 1'b1, 64'h13, 7'd4,  4'd0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 64'h99, 7'd5,  1'b0, 1'b1, 64'h13, 7'd4,  4'd1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 64'h98, 7'd6,  1'b0, 1'b1, 64'h13, 7'd4,  4'd2);
        tbl[6]  = mk(1'b1, 1'b1, 1'b0, 64'h20, 7'd9,  1'b1, 1'b1, 64'h20, 7'd9,  4'd0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 64'h30, 7'd10, 1'b0, 1'b0, 64'h0,  7'd0,  4'd0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, 64'h31, 7'd10, 1'b1, 1'b0, 64'h0,  7'd0,  4'd0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 64'h40, 7'd11, 1'b1, 1'b1, 64'h40, 7'd11, 4'd0);
        tbl[10] = mk(1'b0, 1'b1, 1'b0, 64'h41, 7'd12, 1'b1, 1'b0, 64'h0,  7'd0,  4'd0);

        // Reset with an instruction offered: nothing may be captured.
        reset = 1'b0; valid_i = 1'b1; ready_i = 1'b0; flush_i = 1'b0;
        phySrc1_i = 7'd1; phySrc2_i = 7'd2; phyDest_i = 7'd3; ctrl_i = 32'hCAFE;
        src1Data_i = 64'h55; src2Data_i = 64'h66;
        clear_bypass();
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst valid_o", {63'd0, valid_o}, 64'd0);
        chk("rst ready_o", {63'd0, ready_o}, 64'd1);
        chk("rst stallCnt_o", {60'd0, stallCnt_o}, 64'd0);
        chk("rst src1Data_o", src1Data_o, 64'd0);
        chk("rst src2Data_o", src2Data_o, 64'd0);
        chk("rst phyDest_o", {57'd0, phyDest_o}, 64'd0);
        chk("rst ctrl_o", {32'd0, ctrl_o}, 64'd0);
        reset = 1'b1;

        // Table: streaming, stall, drain+load, flush vs load, load into empty, drain
        for (int i = 0; i < 11; i++) begin
            valid_i = tbl[i].v; ready_i = tbl[i].r; flush_i = tbl[i].f;
            src1Data_i = tbl[i].s1; src2Data_i = tbl[i].s1 ^ 64'hFF00;
            phyDest_i = tbl[i].dest; ctrl_i = 32'(i);
            #1;
            chk($sformatf("tbl%0d ready_o", i), {63'd0, ready_o}, {63'd0, tbl[i].e_rdy});
            tick();
            chk($sformatf("tbl%0d valid_o", i), {63'd0, valid_o}, {63'd0, tbl[i].e_v});
            chk($sformatf("tbl%0d stallCnt_o", i), {60'd0, stallCnt_o}, {60'd0, tbl[i].e_cnt});
            if (tbl[i].e_v) begin
                chk($sformatf("tbl%0d src1Data_o", i), src1Data_o, tbl[i].e_s1);
                chk($sformatf("tbl%0d phyDest_o", i), {57'd0, phyDest_o}, {57'd0, tbl[i].e_dest});
            end
        end

        // Stall snoop; a packet on the load cycle itself must be ignored.
        valid_i = 1'b1; ready_i = 1'b1; flush_i = 1'b0;
        phySrc1_i = 7'd5; src1Data_i = 64'hAA; phySrc2_i = 7'd6; src2Data_i = 64'hBB;
        phyDest_i = 7'd3; ctrl_i = 32'h77;
        set_lane(0, 7'd5, 64'hDEAD);
        tick();
        chk("snoop load src1", src1Data_o, 64'hAA);
        valid_i = 1'b0; ready_i = 1'b0;
        clear_bypass();
        set_lane(1, 7'd5, 64'h1234);
        set_lane(3, 7'd5, 64'h5678);
        tick();
        chk("snoop hi-lane src1", src1Data_o, 64'h5678);
        chk("snoop src2 kept", src2Data_o, 64'hBB);
        chk("snoop cnt1", {60'd0, stallCnt_o}, 64'd1);
        clear_bypass();
        tick();
        chk("snoop cnt2", {60'd0, stallCnt_o}, 64'd2);
        chk("snoop src1 kept", src1Data_o, 64'h5678);
        chk("snoop dest kept", {57'd0, phyDest_o}, 64'd3);

        // Saturation over a long stall
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("sat stallCnt_o", {60'd0, stallCnt_o}, (i + 3 < 15) ? 64'(i + 3) : 64'd15);
        end
        ready_i = 1'b1;
        tick();
        chk("sat drain valid_o", {63'd0, valid_o}, 64'd0);

        // Reset in the middle of a hold
        valid_i = 1'b1; src1Data_i = 64'h321; phyDest_i = 7'd8;
        tick();
        valid_i = 1'b0; ready_i = 1'b0;
        tick(); tick();
        chk("pre-rst cnt", {60'd0, stallCnt_o}, 64'd2);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("midrst valid_o", {63'd0, valid_o}, 64'd0);
        chk("midrst stallCnt_o", {60'd0, stallCnt_o}, 64'd0);
        chk("midrst src1Data_o", src1Data_o, 64'd0);
        chk("midrst ready_o", {63'd0, ready_o}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;

        // Randomized traffic against the reference model
        for (int i = 0; i < 2000; i++) begin
            valid_i   = ($urandom_range(0, 3) != 0);
            ready_i   = $urandom_range(0, 1) == 1;
            flush_i   = ($urandom_range(0, 15) == 0);
            phySrc1_i = SP'($urandom_range(0, 7));
            phySrc2_i = SP'($urandom_range(0, 7));
            phyDest_i = SP'($urandom);
            ctrl_i    = $urandom;
            src1Data_i = {$urandom, $urandom};
            src2Data_i = {$urandom, $urandom};
            for (int k = 0; k < IW; k++) begin
                bypassValid_i[k]         = $urandom_range(0, 1) == 1;
                bypassTag_i[k*SP +: SP]  = SP'($urandom_range(0, 7));
                bypassData_i[k*SD +: SD] = {$urandom, $urandom};
            end
            tick();
            chk_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
